// File: rtl/sprite_plot_arbiter.sv
// sprite_plot_arbiter
//   Shares the single VGA adapter write port between the sprite draw engines
//   (0 = start screen, 1 = player, 2 = monster 1, 3 = monster 2).
//   An engine asks for the port, owns it for a whole sprite, and gives it back
//   on its last pixel. Owners are picked round-robin. A stall watchdog takes
//   the port back from an engine that stops sending pixels.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   req          per-engine port request (level, held until its last pixel)
//   pix_valid    per-engine pixel valid
//   pix_last     per-engine last-pixel flag, only meaningful with pix_valid
//   pix_x/y/col  packed per-engine pixel fields, engine i at [i*W +: W]
//   err_clear    pulse that clears timeout_err
//   grant        registered one-hot grant, also the owner's pixel ready
//   owner        current / most recent owner index
//   busy         high whenever the arbiter is not idle
//   vga_*        registered pixel and write strobe for the adapter
//   timeout_err  sticky flag: the watchdog revoked a grant
module sprite_plot_arbiter #(
   parameter int N_REQ   = 4,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int C_W     = 3,
   parameter int TIMEOUT = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   pix_valid,
   input  logic [N_REQ-1:0]   pix_last,
   input  logic [N_REQ*X_W-1:0] pix_x,
   input  logic [N_REQ*Y_W-1:0] pix_y,
   input  logic [N_REQ*C_W-1:0] pix_colour,
   input  logic               err_clear,
   output logic [N_REQ-1:0]   grant,
   output logic [2:0]         owner,
   output logic               busy,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [C_W-1:0]     vga_colour,
   output logic               vga_plot,
   output logic               timeout_err
);

   localparam int             WD_W      = $clog2(TIMEOUT + 1);
   localparam logic [2:0]     OWNER_RST = 3'(N_REQ - 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RELEASE} state_t;

   state_t            state, state_nxt;
   logic [2:0]        owner_nxt;
   logic [2:0]        winner;
   logic [N_REQ-1:0]  grant_nxt;
   logic [WD_W-1:0]   wd, wd_nxt;
   logic              err_nxt;
   logic              timeout_hit;
   int                rr_best;
   int                rr_dist;

   logic              acc_vld_p0;
   logic              acc_last_p0;
   logic              own_req_p0;
   logic [X_W-1:0]    sel_x_p0;
   logic [Y_W-1:0]    sel_y_p0;
   logic [C_W-1:0]    sel_c_p0;

   // Stage p0: owner's lanes. grant is zero outside STREAM, so masking with it
   // also qualifies acceptance by state and ignores every non-owner.
   always_comb begin
      acc_vld_p0  = |(pix_valid & grant);
      acc_last_p0 = |(pix_valid & pix_last & grant);
      own_req_p0  = |(req & grant);
      sel_x_p0    = '0;
      sel_y_p0    = '0;
      sel_c_p0    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner == i[2:0]) begin
            sel_x_p0 = pix_x[i*X_W +: X_W];
            sel_y_p0 = pix_y[i*Y_W +: Y_W];
            sel_c_p0 = pix_colour[i*C_W +: C_W];
         end
      end
   end

   // Round-robin pick: smallest rotational distance past the previous owner.
   always_comb begin
      winner  = owner;
      rr_best = N_REQ;
      rr_dist = 0;
      for (int i = 0; i < N_REQ; i++) begin
         rr_dist = (i + 2 * N_REQ - int'(owner) - 1) % N_REQ;
         if (req[i] && (rr_dist < rr_best)) begin
            rr_best = rr_dist;
            winner  = i[2:0];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      wd_nxt      = wd;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (|req) begin
               owner_nxt = winner;
               wd_nxt    = '0;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (acc_vld_p0) begin
               wd_nxt = '0;
               if (acc_last_p0) state_nxt = S_RELEASE;
            end else if (!own_req_p0) begin
               state_nxt = S_RELEASE;
            end else begin
               wd_nxt = wd + 1'b1;
               if (wd == WD_LIMIT) begin
                  timeout_hit = 1'b1;
                  state_nxt   = S_RELEASE;
               end
            end
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Output decode for the registered outputs
   always_comb begin
      grant_nxt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         grant_nxt[i] = (state_nxt == S_STREAM) && (owner_nxt == i[2:0]);
      end
      // a set in the same cycle beats a clear
      if (timeout_hit)    err_nxt = 1'b1;
      else if (err_clear) err_nxt = 1'b0;
      else                err_nxt = timeout_err;
   end

   // Stage p1: registered state, grant and VGA write port
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         owner       <= OWNER_RST;
         grant       <= '0;
         wd          <= '0;
         timeout_err <= 1'b0;
         vga_plot    <= 1'b0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         grant       <= grant_nxt;
         wd          <= wd_nxt;
         timeout_err <= err_nxt;
         vga_plot    <= acc_vld_p0;
         if (acc_vld_p0) begin
            vga_x      <= sel_x_p0;
            vga_y      <= sel_y_p0;
            vga_colour <= sel_c_p0;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
module tb_sprite_plot_arbiter;
   localparam int N  = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;
   localparam int TO = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0, pix_valid = '0, pix_last = '0;
   logic [N*XW-1:0] pix_x = '0;
   logic [N*YW-1:0] pix_y = '0;
   logic [N*CW-1:0] pix_colour = '0;
   logic            err_clear = 1'b0;
   logic [N-1:0]    grant;
   logic [2:0]      owner;
   logic            busy, vga_plot, timeout_err;
   logic [XW-1:0]   vga_x;
   logic [YW-1:0]   vga_y;
   logic [CW-1:0]   vga_colour;

   always #5 clock = ~clock;

   sprite_plot_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .req(req), .pix_valid(pix_valid), .pix_last(pix_last),
      .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .err_clear(err_clear),
      .grant(grant), .owner(owner), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot), .timeout_err(timeout_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [CW-1:0] c);
      pix_x[i*XW +: XW]      = x;
      pix_y[i*YW +: YW]      = y;
      pix_colour[i*CW +: CW] = c;
   endtask

   // Reference model: whole-sprite ownership, plain round-robin scan.
   int           m_phase = 0;   // 0 nobody owns, 1 owner streaming, 2 one-cycle gap
   int           m_owner = N - 1;
   int           m_wd = 0;
   int           m_idx, m_pick;
   bit           m_found, m_set;
   logic         m_err = 1'b0, m_plot = 1'b0;
   logic [XW-1:0] m_x = '0;
   logic [YW-1:0] m_y = '0;
   logic [CW-1:0] m_c = '0;

   always @(posedge clock) begin
      if (reset) begin
         m_phase = 0; m_owner = N - 1; m_wd = 0; m_err = 1'b0;
         m_plot = 1'b0; m_x = '0; m_y = '0; m_c = '0;
      end else begin
         m_set  = 1'b0;
         m_plot = 1'b0;
         if (m_phase == 0) begin
            m_found = 1'b0;
            m_pick  = m_owner;
            for (int k = 1; k <= N; k++) begin
               m_idx = (m_owner + k) % N;
               if (!m_found && req[m_idx]) begin
                  m_found = 1'b1;
                  m_pick  = m_idx;
               end
            end
            if (m_found) begin
               m_owner = m_pick; m_wd = 0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (pix_valid[m_owner]) begin
               m_plot = 1'b1;
               m_x = pix_x[m_owner*XW +: XW];
               m_y = pix_y[m_owner*YW +: YW];
               m_c = pix_colour[m_owner*CW +: CW];
               m_wd = 0;
               if (pix_last[m_owner]) m_phase = 2;
            end else if (!req[m_owner]) begin
               m_phase = 2;
            end else begin
               m_wd++;
               if (m_wd == TO) begin
                  m_set = 1'b1; m_phase = 2;
               end
            end
         end else begin
            m_phase = 0;
         end
         if (m_set) m_err = 1'b1;
         else if (err_clear) m_err = 1'b0;
      end
   end

   typedef struct {
      logic          rst;
      logic [N-1:0]  rq, vl, ls;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] c;
      logic [N-1:0]  e_grant;
      logic [2:0]    e_owner;
      logic          e_busy, e_plot;
      logic [XW-1:0] e_x;
      logic [YW-1:0] e_y;
      logic [CW-1:0] e_c;
   } vec_t;

   vec_t tbl[7];
   int   hi;
   int   vprob;
   logic [N-1:0] exp_g;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1, "time limit");
   end

   initial begin
      // Player sprite of three pixels on lane 1.
      tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'd0,  7'd0,  3'd0, 4'b0000, 3'd3, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0};
      tbl[1] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 8'd0,  7'd0,  3'd0, 4'b0010, 3'd1, 1'b1, 1'b0, 8'd0,  7'd0,  3'd0};
      tbl[2] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 8'd10, 7'd20, 3'd5, 4'b0010, 3'd1, 1'b1, 1'b1, 8'd10, 7'd20, 3'd5};
      tbl[3] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 8'd11, 7'd20, 3'd5, 4'b0010, 3'd1, 1'b1, 1'b1, 8'd11, 7'd20, 3'd5};
      tbl[4] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 8'd12, 7'd20, 3'd5, 4'b0000, 3'd1, 1'b1, 1'b1, 8'd12, 7'd20, 3'd5};
      tbl[5] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'd99, 7'd99, 3'd1, 4'b0000, 3'd1, 1'b0, 1'b0, 8'd12, 7'd20, 3'd5};
      tbl[6] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'd99, 7'd99, 3'd1, 4'b0000, 3'd1, 1'b0, 1'b0, 8'd12, 7'd20, 3'd5};

      #2;
      for (int r = 0; r < 7; r++) begin
         reset = tbl[r].rst; req = tbl[r].rq; pix_valid = tbl[r].vl; pix_last = tbl[r].ls;
         set_lane(1, tbl[r].x, tbl[r].y, tbl[r].c);
         step();
         chk($sformatf("t1_row%0d", r),
             {grant, owner, busy, vga_plot, vga_x, vga_y, vga_colour},
             {tbl[r].e_grant, tbl[r].e_owner, tbl[r].e_busy, tbl[r].e_plot,
              tbl[r].e_x, tbl[r].e_y, tbl[r].e_c});
      end

      // T2: all four request continuously, two-pixel sprites.
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b1111; pix_valid = '0; pix_last = '0;
      step();
      for (int s = 0; s < 5; s++) begin
         exp_g = 4'(1 << (s % 4));
         chk($sformatf("t2_grant%0d", s), grant, exp_g);
         pix_valid = exp_g; pix_last = '0;
         step();
         pix_last = exp_g;
         step();
         pix_valid = '0; pix_last = '0;
         chk($sformatf("t2_gap1_%0d", s), grant, 4'b0000);
         step();
         chk($sformatf("t2_gap2_%0d", s), grant, 4'b0000);
         step();
      end
      req = '0; step(); step();

      // T3: non-owner valid/last pulses while m1 owns the port.
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b0100; step();
      chk("t3_grant", grant, 4'b0100);
      set_lane(2, 8'd33, 7'd44, 3'd6); pix_valid = 4'b0100;
      step();
      chk("t3_owner_pixel", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd33, 7'd44, 3'd6});
      set_lane(0, 8'd1, 7'd2, 3'd3); set_lane(1, 8'd1, 7'd2, 3'd3); set_lane(3, 8'd1, 7'd2, 3'd3);
      pix_valid = 4'b1011; pix_last = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t3_ignore%0d", k), {grant, vga_plot, vga_x, vga_y, vga_colour},
             {4'b0100, 1'b0, 8'd33, 7'd44, 3'd6});
      end
      pix_valid = '0; pix_last = '0; req = '0; step(); step();

      // T4: player stalls with request held; watchdog must revoke after TO cycles.
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b0010; step();
      hi = 0;
      for (int c = 0; c < 20; c++) begin
         if (grant != 4'b0010) break;
         hi++;
         step();
      end
      req = '0;
      chk("t4_stall_cycles", hi, TO);
      chk("t4_err_set", {grant, timeout_err}, {4'b0000, 1'b1});
      step(); step();
      chk("t4_err_sticky", timeout_err, 1'b1);
      err_clear = 1'b1; step(); err_clear = 1'b0;
      chk("t4_err_clear", timeout_err, 1'b0);

      // T5: m2 abandons its sprite after two pixels.
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b1000; step();
      chk("t5_grant_m2", grant, 4'b1000);
      pix_valid = 4'b1000; step(); step();
      pix_valid = '0; req = 4'b0001;
      step();
      chk("t5_release", {grant, timeout_err, busy}, {4'b0000, 1'b0, 1'b1});
      step();
      chk("t5_idle", {grant, busy}, {4'b0000, 1'b0});
      step();
      chk("t5_next_grant", {grant, timeout_err}, {4'b0001, 1'b0});
      req = '0; step(); step();

      // T6: reset in the middle of a streaming sprite.
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b0100; step();
      set_lane(2, 8'd7, 7'd8, 3'd2); pix_valid = 4'b0100;
      step();
      chk("t6_plotting", vga_plot, 1'b1);
      reset = 1'b1; step();
      chk("t6_reset", {vga_plot, grant, owner, busy, vga_x}, {1'b0, 4'b0000, 3'd3, 1'b0, 8'd0});
      reset = 1'b0; pix_valid = '0; req = '0;

      // Random traffic against the reference model.
      reset = 1'b1; step(); reset = 1'b0;
      vprob = 50;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (cyc % 250 == 0) vprob = ($urandom_range(0, 1) == 1) ? 50 : 8;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            pix_valid[i] = ($urandom_range(0, 99) < vprob);
            pix_last[i]  = ($urandom_range(0, 3) == 0);
         end
         pix_x      = $urandom;
         pix_y      = 28'($urandom);
         pix_colour = 12'($urandom);
         err_clear  = ($urandom_range(0, 19) == 0);
         reset      = ($urandom_range(0, 299) == 0);
         step();
         chk("rand", {grant, owner, busy, vga_plot, vga_x, vga_y, vga_colour, timeout_err},
             {(m_phase == 1) ? 4'(1 << m_owner) : 4'b0000, 3'(m_owner), (m_phase != 0),
              m_plot, m_x, m_y, m_c, m_err});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
